// File: rtl/ip_tx_arbiter_if.sv
// Requester, arbiter and tx-engine signal bundle.
// Field vectors are ascending: requester i owns slice i.
interface ip_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    REQ_VALID;
  logic [0:32*NUM_REQ-1] REQ_IP_ADDRESS;
  logic [0:48*NUM_REQ-1] REQ_MAC_ADDRESS;
  logic [0:10*NUM_REQ-1] REQ_MESSAGE;
  logic [NUM_REQ-1:0]    REQ_GRANT;
  logic [NUM_REQ-1:0]    REQ_DONE;
  logic [0:31]           RECIPIENT_IP_ADDRESS;
  logic [0:47]           RECIPIENT_MAC_ADDRESS;
  logic [0:9]            RECIPIENT_MESSAGE;
  logic                  START_IP_TXN;
  logic                  READY_FOR_SEND;
  logic [15:0]           TXN_COUNT;

  modport master (
    input  REQ_VALID,
    input  REQ_IP_ADDRESS,
    input  REQ_MAC_ADDRESS,
    input  REQ_MESSAGE,
    input  READY_FOR_SEND,
    output REQ_GRANT,
    output REQ_DONE,
    output RECIPIENT_IP_ADDRESS,
    output RECIPIENT_MAC_ADDRESS,
    output RECIPIENT_MESSAGE,
    output START_IP_TXN,
    output TXN_COUNT
  );

  modport slave (
    output REQ_VALID,
    output REQ_IP_ADDRESS,
    output REQ_MAC_ADDRESS,
    output REQ_MESSAGE,
    output READY_FOR_SEND,
    input  REQ_GRANT,
    input  REQ_DONE,
    input  RECIPIENT_IP_ADDRESS,
    input  RECIPIENT_MAC_ADDRESS,
    input  RECIPIENT_MESSAGE,
    input  START_IP_TXN,
    input  TXN_COUNT
  );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Shares one ip_packet_tx engine among NUM_REQ requesters, round-robin.
// Define IP_TX_ARB_STRICT_PRIO_EN for lowest-index-wins priority instead.
module ip_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input logic             ACLK,
  input logic             ARESET,
  ip_tx_arbiter_if.master bus
);
  localparam int W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef logic [W-1:0] idx_t;
  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t      state;
  idx_t        cur;
  idx_t        win;
  logic        found;
  logic [31:0] sel_ip;
  logic [47:0] sel_mac;
  logic [9:0]  sel_msg;

`ifdef IP_TX_ARB_STRICT_PRIO_EN
  // Lowest valid index wins; descending scan leaves the lowest last
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.REQ_VALID[k]) begin
        found = 1'b1;
        win   = idx_t'(k);
      end
    end
  end
`else
  idx_t       ptr;
  logic [W:0] rot;
  idx_t       ri;

  // First valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    rot   = '0;
    ri    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot = {1'b0, ptr} + (W+1)'(k);
      if (rot >= (W+1)'(NUM_REQ))
        rot = rot - (W+1)'(NUM_REQ);
      ri = rot[W-1:0];
      if (!found && bus.REQ_VALID[ri]) begin
        found = 1'b1;
        win   = ri;
      end
    end
  end
`endif

  // Route the winner's fields toward the capture registers
  always_comb begin
    sel_ip  = '0;
    sel_mac = '0;
    sel_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == idx_t'(i)) begin
        sel_ip  = bus.REQ_IP_ADDRESS[32*i +: 32];
        sel_mac = bus.REQ_MAC_ADDRESS[48*i +: 48];
        sel_msg = bus.REQ_MESSAGE[10*i +: 10];
      end
    end
  end

  // Transaction FSM with registered pulses and held engine fields
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state                     <= IDLE;
      cur                       <= '0;
`ifndef IP_TX_ARB_STRICT_PRIO_EN
      ptr                       <= '0;
`endif
      bus.REQ_GRANT             <= '0;
      bus.REQ_DONE              <= '0;
      bus.START_IP_TXN          <= 1'b0;
      bus.RECIPIENT_IP_ADDRESS  <= '0;
      bus.RECIPIENT_MAC_ADDRESS <= '0;
      bus.RECIPIENT_MESSAGE     <= '0;
      bus.TXN_COUNT             <= '0;
    end else begin
      bus.REQ_GRANT    <= '0;
      bus.REQ_DONE     <= '0;
      bus.START_IP_TXN <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.READY_FOR_SEND && found) begin
            bus.REQ_GRANT             <= ONE << win;
            bus.RECIPIENT_IP_ADDRESS  <= sel_ip;
            bus.RECIPIENT_MAC_ADDRESS <= sel_mac;
            bus.RECIPIENT_MESSAGE     <= sel_msg;
            cur                       <= win;
            state                     <= START;
          end
        end
        START: begin
          bus.START_IP_TXN <= 1'b1;
          state            <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.READY_FOR_SEND)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.READY_FOR_SEND) begin
            bus.REQ_DONE <= ONE << cur;
            if (bus.TXN_COUNT != 16'hFFFF)
              bus.TXN_COUNT <= bus.TXN_COUNT + 16'd1;
`ifndef IP_TX_ARB_STRICT_PRIO_EN
            if (cur == idx_t'(NUM_REQ - 1))
              ptr <= '0;
            else
              ptr <= cur + idx_t'(1);
`endif
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one ip_packet_tx engine (legal range 2..8).
REQ-002 ACLK  input  1  sole clock; all state updates on rising edge.
REQ-003 ARESET  input  1  asynchronous, active-low reset.
REQ-004 REQ_VALID  input  NUM_REQ  bit i high = requester i holds a pending packet.
REQ-005 REQ_IP_ADDRESS  input  [0:32*NUM_REQ-1]  requester i at bits [32*i : 32*i+31].
REQ-006 REQ_MAC_ADDRESS  input  [0:48*NUM_REQ-1]  requester i at bits [48*i : 48*i+47].
REQ-007 REQ_MESSAGE  input  [0:10*NUM_REQ-1]  requester i at bits [10*i : 10*i+9].
REQ-008 REQ_GRANT  output  NUM_REQ  one-hot, one-cycle pulse; requester fields captured this cycle.
REQ-009 REQ_DONE  output  NUM_REQ  one-hot, one-cycle pulse when granted packet has fully left the engine.
REQ-010 RECIPIENT_IP_ADDRESS  output  [0:31]  to engine, held stable from START through WAIT_DONE.
REQ-011 RECIPIENT_MAC_ADDRESS  output  [0:47]  to engine, same stability.
REQ-012 RECIPIENT_MESSAGE  output  [0:9]  to engine, same stability.
REQ-013 START_IP_TXN  output  1  one-cycle start pulse to engine.
REQ-014 READY_FOR_SEND  input  1  engine idle indication.
REQ-015 TXN_COUNT  output  16  count of completed transactions, saturating at 16'hFFFF.

Function
REQ-016 FSM states IDLE, START, WAIT_BUSY, WAIT_DONE; exactly one active.
REQ-017 IDLE: if READY_FOR_SEND=1 and REQ_VALID!=0, pick winner, pulse REQ_GRANT[winner], latch winner's fields into RECIPIENT_* registers, go START; else stay.
REQ-018 START: START_IP_TXN=1 for exactly this cycle; go WAIT_BUSY.
REQ-019 WAIT_BUSY: stay while READY_FOR_SEND=1; on READY_FOR_SEND=0 go WAIT_DONE.
REQ-020 WAIT_DONE: stay while READY_FOR_SEND=0; on READY_FOR_SEND=1 pulse REQ_DONE[winner], increment TXN_COUNT, advance pointer, go IDLE.
REQ-021 Grant-to-start latency exactly 1 cycle; minimum grant-to-grant spacing 4 cycles (IDLE,START,WAIT_BUSY,WAIT_DONE).
REQ-022 Round-robin: search starts at pointer P, wraps modulo NUM_REQ; after completion P = winner+1 mod NUM_REQ.
REQ-023 REQ_VALID deasserted after grant has no effect on the in-flight transaction.
REQ-024 REQ_VALID changes on non-winners while busy are ignored until return to IDLE.
REQ-025 READY_FOR_SEND=0 in IDLE: no grant issued, requests wait.
REQ-026 Requester must drop REQ_VALID in the cycle after REQ_GRANT unless it has a further packet; arbiter does not queue.
REQ-027 TXN_COUNT holds at 16'hFFFF once reached.

Reset
REQ-028 ARESET=0 forces immediately: state IDLE, P=0, REQ_GRANT=0, REQ_DONE=0, START_IP_TXN=0, RECIPIENT_*=0, TXN_COUNT=0.
REQ-029 Reset mid-transaction aborts without REQ_DONE; first grant after release follows REQ-017 with P=0.

Configuration
REQ-030 Macro IP_TX_ARB_STRICT_PRIO_EN: when defined, winner is lowest-index valid requester and P is unused; when undefined, round-robin per REQ-022.

Verification
REQ-031 Single request: REQ_VALID=4'b0010, IP 32'h0a0b0c0d, MAC 48'h32dabbadebd5, MSG 10'h1ff, engine model -> REQ_GRANT=4'b0010, START_IP_TXN next cycle, RECIPIENT_* match, REQ_DONE=4'b0010, TXN_COUNT=1.
REQ-032 All four valid continuously, round-robin build -> grant order 0,1,2,3,0; strict-prio build -> 0,0,0,0.
REQ-033 READY_FOR_SEND held 0 for 10 cycles with REQ_VALID=4'b0001 -> no grant until READY_FOR_SEND=1, then grant within 1 cycle.
REQ-034 Requester 2 changes REQ_IP_ADDRESS to 32'hdeadbeef during WAIT_DONE -> RECIPIENT_IP_ADDRESS unchanged until next grant.
REQ-035 ARESET=0 asserted in WAIT_DONE -> all outputs 0 same cycle, no REQ_DONE, TXN_COUNT=0.
REQ-036 TXN_COUNT preloaded path: 65536 completions -> TXN_COUNT=16'hFFFF and holds.
